hazard_fwd_unit: RTL and testbench

Decode-side consumer of the execute-stage forwarding bus (`EX_raw_sel`/`EX_raw_val`) and writeback bus. It selects forwarded operand values for the instruction in decode and detects load-use hazards. It holds decode stalled and injects execute bubbles until data memory returns the load. It sits between the register file read ports and the ID/EX pipeline register, and drives that register's stall input.

---
 rtl/hazard_fwd_unit_if.sv | 41 ++++
 rtl/hazard_fwd_unit.sv | 145 ++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_fwd_unit_if.sv
// Decode-side forwarding/hazard bundle: pipeline operand, EX and MEM buses plus
// the stall/bubble controls returned by the hazard unit.
interface hazard_fwd_unit_if;
  logic [4:0]  ID_rs1_sel;
  logic [4:0]  ID_rs2_sel;
  logic        ID_rs1_used;
  logic        ID_rs2_used;
  logic [31:0] ID_rf_rs1_val;
  logic [31:0] ID_rf_rs2_val;
  logic [4:0]  EX_raw_sel;
  logic [31:0] EX_raw_val;
  logic        EX_raw_wr_en;
  logic        EX_raw_ld;
  logic [4:0]  MEM_wb_sel;
  logic [31:0] MEM_wb_val;
  logic        MEM_wb_en;
  logic        mem_ready;
  logic        flush;
  logic [31:0] ID_rs1_fwd;
  logic [31:0] ID_rs2_fwd;
  logic        ID_stall;
  logic        EX_bubble;
  logic        timeout_err;
  logic [31:0] stall_count;

  modport master (
    output ID_rs1_sel, ID_rs2_sel, ID_rs1_used, ID_rs2_used,
    output ID_rf_rs1_val, ID_rf_rs2_val,
    output EX_raw_sel, EX_raw_val, EX_raw_wr_en, EX_raw_ld,
    output MEM_wb_sel, MEM_wb_val, MEM_wb_en, mem_ready, flush,
    input  ID_rs1_fwd, ID_rs2_fwd, ID_stall, EX_bubble, timeout_err, stall_count
  );

  modport slave (
    input  ID_rs1_sel, ID_rs2_sel, ID_rs1_used, ID_rs2_used,
    input  ID_rf_rs1_val, ID_rf_rs2_val,
    input  EX_raw_sel, EX_raw_val, EX_raw_wr_en, EX_raw_ld,
    input  MEM_wb_sel, MEM_wb_val, MEM_wb_en, mem_ready, flush,
    output ID_rs1_fwd, ID_rs2_fwd, ID_stall, EX_bubble, timeout_err, stall_count
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding for decode and load-use stall control: stalls decode and
// bubbles execute until data memory returns the pending load.
module hazard_fwd_unit #(
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_n,
  hazard_fwd_unit_if.slave  bus
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    WAIT_MEM = 1'b1
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        stall_s;
  logic        bubble_s;
  logic        hazard_s;

  // A load in EX only carries an address, so it must never be forwarded from EX.
  function automatic logic [31:0] fwd_value(
    input logic [4:0]  sel,
    input logic [31:0] rf_val,
    input logic [4:0]  ex_sel,
    input logic [31:0] ex_val,
    input logic        ex_wr_en,
    input logic        ex_ld,
    input logic [4:0]  mem_sel,
    input logic [31:0] mem_val,
    input logic        mem_en
  );
    logic [31:0] val;
    if (sel == 5'd0) begin
      val = 32'd0;
    end else if (ex_wr_en && !ex_ld && (ex_sel == sel)) begin
      val = ex_val;
    end else if (mem_en && (mem_sel == sel)) begin
      val = mem_val;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  assign bus.ID_rs1_fwd = fwd_value(bus.ID_rs1_sel, bus.ID_rf_rs1_val,
                                    bus.EX_raw_sel, bus.EX_raw_val, bus.EX_raw_wr_en,
                                    bus.EX_raw_ld, bus.MEM_wb_sel, bus.MEM_wb_val,
                                    bus.MEM_wb_en);
  assign bus.ID_rs2_fwd = fwd_value(bus.ID_rs2_sel, bus.ID_rf_rs2_val,
                                    bus.EX_raw_sel, bus.EX_raw_val, bus.EX_raw_wr_en,
                                    bus.EX_raw_ld, bus.MEM_wb_sel, bus.MEM_wb_val,
                                    bus.MEM_wb_en);

  assign hazard_s = bus.EX_raw_wr_en && bus.EX_raw_ld && (bus.EX_raw_sel != 5'd0) &&
                    ((bus.ID_rs1_used && (bus.ID_rs1_sel == bus.EX_raw_sel)) ||
                     (bus.ID_rs2_used && (bus.ID_rs2_sel == bus.EX_raw_sel)));

  // Next-state, wait counter and stall/bubble decode; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_s    = 1'b0;
    bubble_s   = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard_s) begin
          stall_s    = 1'b1;
          bubble_s   = 1'b1;
          state_d    = WAIT_MEM;
          wait_cnt_d = 8'd0;
        end else begin
          state_d    = RUN;
        end
      end
      WAIT_MEM: begin
        if (!bus.mem_ready) begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
          if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
    if (bus.flush) begin
      state_d    = RUN;
      wait_cnt_d = 8'd0;
      stall_s    = 1'b0;
      bubble_s   = 1'b0;
    end else begin
      stall_s    = stall_s;
    end
  end

  // Sticky timeout and the running stall-cycle total.
  always_comb begin
    timeout_err_d = timeout_err_q;
    stall_count_d = stall_count_q;
    if ((state_q == WAIT_MEM) && !bus.flush && (wait_cnt_d == TIMEOUT_C)) begin
      timeout_err_d = 1'b1;
    end else begin
      timeout_err_d = timeout_err_q;
    end
    if (stall_s) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      timeout_err_q <= 1'b0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.ID_stall    = stall_s;
  assign bus.EX_bubble   = bubble_s;
  assign bus.timeout_err = timeout_err_q;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed and randomized bench for hazard_fwd_unit against a cycle-level
// behavioural model of forwarding priority and load-use waiting.
module tb_hazard_fwd_unit;

  localparam int TO = 3;

  logic clk;
  logic rst_n;
  hazard_fwd_unit_if bus ();

  hazard_fwd_unit #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total_cnt = 0;
  int unsigned pass_cnt  = 0;

  // model state
  bit          m_wait;
  int          m_waits;
  bit          m_err;
  logic [31:0] m_stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_fwd(input logic [4:0] sel, input logic [31:0] rf);
    if (sel == 5'd0) return 32'd0;
    if (bus.EX_raw_wr_en && !bus.EX_raw_ld && bus.EX_raw_sel == sel) return bus.EX_raw_val;
    if (bus.MEM_wb_en && bus.MEM_wb_sel == sel) return bus.MEM_wb_val;
    return rf;
  endfunction

  function automatic bit m_hazard();
    if (!(bus.EX_raw_wr_en && bus.EX_raw_ld) || bus.EX_raw_sel == 5'd0) return 1'b0;
    return (bus.ID_rs1_used && bus.ID_rs1_sel == bus.EX_raw_sel) ||
           (bus.ID_rs2_used && bus.ID_rs2_sel == bus.EX_raw_sel);
  endfunction

  function automatic bit m_stall();
    if (bus.flush) return 1'b0;
    if (m_wait) return !bus.mem_ready;
    return m_hazard();
  endfunction

  task automatic idle_inputs();
    bus.ID_rs1_sel = 5'd0;  bus.ID_rs2_sel = 5'd0;
    bus.ID_rs1_used = 1'b0; bus.ID_rs2_used = 1'b0;
    bus.ID_rf_rs1_val = 32'd0; bus.ID_rf_rs2_val = 32'd0;
    bus.EX_raw_sel = 5'd0; bus.EX_raw_val = 32'd0;
    bus.EX_raw_wr_en = 1'b0; bus.EX_raw_ld = 1'b0;
    bus.MEM_wb_sel = 5'd0; bus.MEM_wb_val = 32'd0; bus.MEM_wb_en = 1'b0;
    bus.mem_ready = 1'b0; bus.flush = 1'b0;
  endtask

  // Check every output at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    bit st;
    @(negedge clk);
    st = m_stall();
    chk("rs1_fwd", bus.ID_rs1_fwd, m_fwd(bus.ID_rs1_sel, bus.ID_rf_rs1_val));
    chk("rs2_fwd", bus.ID_rs2_fwd, m_fwd(bus.ID_rs2_sel, bus.ID_rf_rs2_val));
    chk("stall", {31'd0, bus.ID_stall}, {31'd0, st});
    chk("bubble", {31'd0, bus.EX_bubble}, {31'd0, st});
    chk("timeout_err", {31'd0, bus.timeout_err}, {31'd0, m_err});
    chk("stall_count", bus.stall_count, m_stalls);
    @(posedge clk);
    if (bus.flush) begin
      m_wait = 1'b0; m_waits = 0;
    end else if (m_wait) begin
      if (bus.mem_ready) m_wait = 1'b0;
      else if (m_waits < 255) m_waits++;
      if (m_waits == TO) m_err = 1'b1;
    end else if (m_hazard()) begin
      m_wait = 1'b1; m_waits = 0;
    end
    if (st) m_stalls = m_stalls + 32'd1;
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    idle_inputs();
    rst_n = 1'b0;
    m_wait = 1'b0; m_waits = 0; m_err = 1'b0; m_stalls = 32'd0;
    #1;
    chk({tag, "_stall"}, {31'd0, bus.ID_stall}, 32'd0);
    chk({tag, "_count"}, bus.stall_count, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.timeout_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [4:0] rd, input bit on_rs2);
    bus.EX_raw_sel = rd; bus.EX_raw_wr_en = 1'b1; bus.EX_raw_ld = 1'b1;
    bus.EX_raw_val = 32'h0000_1000;
    if (on_rs2) begin bus.ID_rs2_sel = rd; bus.ID_rs2_used = 1'b1; end
    else begin bus.ID_rs1_sel = rd; bus.ID_rs1_used = 1'b1; end
  endtask

  initial begin
    do_reset("init");

    // operand priority
    bus.ID_rs1_sel = 5'd5; bus.ID_rf_rs1_val = 32'h33;
    bus.EX_raw_sel = 5'd5; bus.EX_raw_val = 32'h11; bus.EX_raw_wr_en = 1'b1;
    bus.MEM_wb_sel = 5'd5; bus.MEM_wb_val = 32'h22; bus.MEM_wb_en = 1'b1;
    #1 chk("prio_ex", bus.ID_rs1_fwd, 32'h11);
    cycle();
    bus.EX_raw_wr_en = 1'b0;
    #1 chk("prio_mem", bus.ID_rs1_fwd, 32'h22);
    cycle();
    bus.MEM_wb_en = 1'b0;
    #1 chk("prio_rf", bus.ID_rs1_fwd, 32'h33);
    cycle();
    bus.ID_rs1_sel = 5'd0;
    #1 chk("prio_zero", bus.ID_rs1_fwd, 32'h0);
    cycle();

    // one-cycle load-use
    idle_inputs();
    load_use(5'd7, 1'b1);
    cycle();
    bus.EX_raw_wr_en = 1'b0; bus.EX_raw_ld = 1'b0;
    bus.mem_ready = 1'b1; bus.MEM_wb_en = 1'b1; bus.MEM_wb_sel = 5'd7;
    bus.MEM_wb_val = 32'hDEADBEEF;
    #1 chk("lu1_fwd", bus.ID_rs2_fwd, 32'hDEADBEEF);
    cycle();
    chk("lu1_count", bus.stall_count, 32'd1);

    // slow memory: four extra wait cycles
    do_reset("rst_a");
    load_use(5'd9, 1'b0);
    cycle();
    bus.EX_raw_wr_en = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    bus.mem_ready = 1'b1; bus.MEM_wb_en = 1'b1; bus.MEM_wb_sel = 5'd9;
    cycle();
    chk("slow_count", bus.stall_count, 32'd5);

    // flush in second wait cycle, then flush coincident with hazard
    do_reset("rst_b");
    load_use(5'd4, 1'b1);
    cycle();
    bus.EX_raw_wr_en = 1'b0;
    cycle();
    bus.flush = 1'b1;
    #1 chk("flush_wait", {31'd0, bus.ID_stall}, 32'd0);
    cycle();
    bus.flush = 1'b0;
    #1 chk("flush_run", {31'd0, bus.ID_stall}, 32'd0);
    cycle();
    load_use(5'd4, 1'b1);
    bus.flush = 1'b1;
    #1 chk("flush_haz", {31'd0, bus.ID_stall}, 32'd0);
    cycle();

    // timeout with memory stuck low
    do_reset("rst_c");
    load_use(5'd12, 1'b0);
    cycle();
    bus.EX_raw_wr_en = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("to_set", {31'd0, bus.timeout_err}, 32'd1);
    chk("to_stalling", {31'd0, bus.ID_stall}, 32'd1);
    cycle();
    bus.mem_ready = 1'b1;
    cycle();
    cycle();
    chk("to_sticky", {31'd0, bus.timeout_err}, 32'd1);

    // asynchronous reset mid-wait
    bus.mem_ready = 1'b0;
    load_use(5'd3, 1'b1);
    cycle();
    bus.EX_raw_wr_en = 1'b0;
    cycle();
    cycle();
    do_reset("async");

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bus.ID_rs1_sel = 5'($urandom_range(0, 3));
      bus.ID_rs2_sel = 5'($urandom_range(0, 3));
      bus.ID_rs1_used = 1'($urandom);
      bus.ID_rs2_used = 1'($urandom);
      bus.ID_rf_rs1_val = $urandom;
      bus.ID_rf_rs2_val = $urandom;
      bus.EX_raw_sel = 5'($urandom_range(0, 3));
      bus.EX_raw_val = $urandom;
      bus.EX_raw_wr_en = 1'($urandom);
      bus.EX_raw_ld = 1'($urandom);
      bus.MEM_wb_sel = 5'($urandom_range(0, 3));
      bus.MEM_wb_val = $urandom;
      bus.MEM_wb_en = 1'($urandom);
      bus.mem_ready = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      cycle();
      if (n == 200) do_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
